serial_subtractor: RTL



---
 rtl/arith_pkg.sv | 13 +
 rtl/full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks.
// Holds the default operand width and the sequencer state encoding.
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives: d = a - b - bin.
// bout is set when the bit position has to borrow from the next one.
module full_subtractor (
    input  wire a,
    input  wire b,
    input  wire bin,
    output wire d,
    output wire bout
);

    wire a_xor_b;
    wire a_n;
    wire a_xnor_b;
    wire brw_ab;
    wire brw_in;

    xor g_x0 (a_xor_b, a, b);
    xor g_x1 (d, a_xor_b, bin);
    not g_n0 (a_n, a);
    not g_n1 (a_xnor_b, a_xor_b);
    and g_a0 (brw_ab, a_n, b);
    and g_a1 (brw_in, a_xnor_b, bin);
    or  g_o0 (bout, brw_ab, brw_in);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: in_a - in_b, one bit per clock, LSB first,
// through a single full_subtractor cell and a borrow flop.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   out,
    output logic             out_v,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Handshake: start is sampled only in IDLE or DONE; busy is high while a
    // subtraction runs (start ignored, not queued); done pulses for one cycle
    // and out/out_v are valid from that cycle until the next completion.

    arith_state_e      state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  a_q,       a_d;
    logic [WIDTH-1:0]  b_q,       b_d;
    logic [WIDTH-1:0]  res_q,     res_d;
    logic              borrow_q,  borrow_d;
    logic              a_msb_q,   a_msb_d;
    logic              b_msb_q,   b_msb_d;
    logic [WIDTH:0]    out_q,     out_d;
    logic              out_v_q,   out_v_d;

    wire cell_d;
    wire cell_bout;

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        borrow_d  = borrow_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        out_d     = out_q;
        out_v_d   = out_v_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    a_d       = in_a;
                    b_d       = in_b;
                    a_msb_d   = in_a[WIDTH-1];
                    b_msb_d   = in_b[WIDTH-1];
                    res_d     = '0;
                    borrow_d  = 1'b0;
                    bit_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d       = {1'b0, a_q[WIDTH-1:1]};
                b_d       = {1'b0, b_q[WIDTH-1:1]};
                res_d     = {cell_d, res_q[WIDTH-1:1]};
                borrow_d  = cell_bout;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    out_d   = {cell_bout, cell_d, res_q[WIDTH-1:1]};
                    // Signed overflow only when operand signs differ and the
                    // result sign disagrees with the minuend.
                    out_v_d = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            borrow_q  <= 1'b0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            out_q     <= '0;
            out_v_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            borrow_q  <= borrow_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            out_q     <= out_d;
            out_v_q   <= out_v_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign out       = out_q;
    assign out_v     = out_v_q;
    assign dbg_state = state_q;

endmodule : serial_subtractor
